// File: rtl/enable_scheduler.sv
// Round-robin scheduler for a shared, gated register clock.
// One requester at a time owns the clock enable for a burst of len+1 pulses.
// The state machine runs on the rising edge. The enable register runs on the
// falling edge, so enb only moves while clk is low and eclk = clk & enb
// never glitches or produces a short pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner; arbitrate req starting at ptr on each rising edge
// ACTIVE | winner owns the clock; count the burst down, watch for abort
// GAP    | one-cycle dead time after a burst; requests wait for IDLE
module enable_scheduler #(
   parameter int NREQ = 4,
   parameter int LW   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   len,
   output logic [NREQ-1:0] gnt,
   output logic            enb,
   output logic            busy,
   output logic            done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [LW-1:0]   cnt;
   logic [LW-1:0]   cnt_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [PW-1:0]   win;
   logic [PW-1:0]   win_nxt;
   logic            done_nxt;

   logic            arb_found;
   logic [PW-1:0]   arb_idx;
   logic [PW-1:0]   arb_cand;

   // Rotating priority search: first set req bit at ptr, ptr+1, ...
   // The index wraps naturally because NREQ is a power of two.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = ptr;
      arb_cand  = ptr;
      for (int i = 0; i < NREQ; i++) begin
         arb_cand = ptr + PW'(i);
         if (!arb_found && req[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      win_nxt   = win;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (arb_found) begin
               state_nxt = ACTIVE;
               win_nxt   = arb_idx;
               gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
               cnt_nxt   = len;
            end
         end
         ACTIVE: begin
            // Dropping the winner's request ends the burst the same way
            // as running out of count, including the done pulse.
            if ((cnt == '0) || !req[win]) begin
               state_nxt = GAP;
               gnt_nxt   = '0;
               done_nxt  = 1'b1;
               ptr_nxt   = win + PW'(1);
            end else begin
               cnt_nxt = cnt - LW'(1);
            end
         end
         GAP: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Rising-edge state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         cnt   <= '0;
         ptr   <= '0;
         win   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         cnt   <= cnt_nxt;
         ptr   <= ptr_nxt;
         win   <= win_nxt;
         done  <= done_nxt;
      end
   end

   // Falling-edge enable register; reset clears it at once so a killed
   // burst loses its remaining eclk pulses immediately.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enb <= 1'b0;
      end else begin
         enb <= (state == ACTIVE);
      end
   end

   // Busy covers the burst and the dead cycle after it.
   always_comb begin
      busy = (state == ACTIVE) || (state == GAP);
   end

endmodule

// File: tb/tb_enable_scheduler.sv
// Self-checking bench for enable_scheduler: table-driven bursts with a
// scoreboard of expected {grant, pulse count} plus hand-written sequences
// for rotation, abort and mid-burst reset.
module tb_enable_scheduler;

   typedef struct {
      logic [3:0] req;
      logic [2:0] len;
      int         abort_n;
      logic [3:0] exp_gnt;
      int         exp_pulses;
   } vec_t;

   typedef struct {
      logic [3:0] g;
      int         p;
   } sb_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = '0;
   logic [2:0] len   = '0;
   logic [3:0] gnt;
   logic       enb;
   logic       busy;
   logic       done;

   int         checks    = 0;
   int         failures  = 0;
   int         cyc       = 0;
   int         pulse_cnt = 0;
   logic [3:0] cur_gnt   = '0;
   logic       prev_done = 1'b0;
   sb_t        sbq[$];
   vec_t       vt[10];

   enable_scheduler #(.NREQ(4), .LW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .len   (len),
      .gnt   (gnt),
      .enb   (enb),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // enb must only move while clk is low (reset excepted).
   always @(enb) begin
      if (rst_n) chk("enb_edge_clk_low", clk, 0);
   end

   // Monitor: predicts eclk pulses from enb seen in the low phase, checks
   // grant shape, and compares each finished burst against the scoreboard.
   always @(negedge clk) begin
      sb_t e;
      #1;
      if (!rst_n) begin
         pulse_cnt = 0;
         cur_gnt   = '0;
         prev_done = 1'b0;
      end else begin
         if (enb) pulse_cnt++;
         if (gnt != 0 && cur_gnt == 0) cur_gnt = gnt;
         chk("gnt_onehot", ($countones(gnt) <= 1), 1);
         if (done) begin
            chk("done_one_cycle", prev_done, 0);
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
               e = sbq.pop_front();
               chk("burst_gnt", cur_gnt, e.g);
               chk("burst_pulses", pulse_cnt, e.p);
            end
            chk("gnt_zero_at_done", gnt, 0);
            chk("enb_low_at_done", enb, 0);
            pulse_cnt = 0;
            cur_gnt   = '0;
         end
         prev_done = done;
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      req   = '0;
      len   = '0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_enb", enb, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_burst(input vec_t v);
      int n;
      sbq.push_back('{v.exp_gnt, v.exp_pulses});
      step();
      req = v.req;
      len = v.len;
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      chk("grant", gnt, v.exp_gnt);
      chk("busy_active", busy, 1);
      // Non-winning request bits and len are scrambled; neither may matter.
      req = (4'($urandom) & ~gnt) | gnt;
      len = 3'($urandom);
      if (v.abort_n > 0) begin
         n = 0;
         while (pulse_cnt < v.abort_n && n < 40) begin step(); n++; end
         req = req & ~gnt;
      end
      n = 0;
      while (!done && n < 40) begin step(); n++; end
      chk("done_seen", done, 1);
      chk("busy_gap", busy, 1);
      req = '0;
      step();
      chk("busy_idle", busy, 0);
      chk("gnt_idle", gnt, 0);
   endtask

   initial begin
      int         ngr;
      int         n;
      logic [3:0] last;
      logic [3:0] rot_g[5];
      int         rot_c[5];
      logic [3:0] rot_exp[5];

      vt[0] = '{4'b0001, 3'd2, 0, 4'b0001, 3};
      vt[1] = '{4'b0011, 3'd0, 0, 4'b0010, 1};
      vt[2] = '{4'b1001, 3'd3, 0, 4'b1000, 4};
      vt[3] = '{4'b0110, 3'd7, 4, 4'b0010, 4};
      vt[4] = '{4'b0011, 3'd1, 0, 4'b0001, 2};
      vt[5] = '{4'b1111, 3'd4, 0, 4'b0010, 5};
      vt[6] = '{4'b0100, 3'd7, 0, 4'b0100, 8};
      vt[7] = '{4'b1010, 3'd2, 2, 4'b1000, 2};
      vt[8] = '{4'b1100, 3'd0, 0, 4'b0100, 1};
      vt[9] = '{4'b0111, 3'd5, 0, 4'b0001, 6};
      rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
      rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

      do_reset();
      for (int i = 0; i < 10; i++) run_burst(vt[i]);
      step();
      chk("sb_drained_table", sbq.size(), 0);

      // Held 1111 with len=0: grants rotate, three cycles apart.
      do_reset();
      for (int i = 0; i < 5; i++) sbq.push_back('{rot_exp[i], 1});
      step();
      req  = 4'b1111;
      len  = 3'd0;
      ngr  = 0;
      last = '0;
      n    = 0;
      while (n < 40) begin
         step();
         n++;
         if (gnt != 0 && last == 0 && ngr < 5) begin
            rot_g[ngr] = gnt;
            rot_c[ngr] = cyc;
            ngr++;
         end
         last = gnt;
         if (ngr == 5 && done) break;
      end
      req = '0;
      chk("rot_count", ngr, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < ngr) begin
            chk("rot_gnt", rot_g[i], rot_exp[i]);
            if (i > 0) chk("rot_spacing", rot_c[i] - rot_c[i-1], 3);
         end
      end
      step();
      step();
      chk("sb_drained_rot", sbq.size(), 0);

      // Reset in the high phase of a burst to requester 2.
      do_reset();
      step();
      req = 4'b0100;
      len = 3'd5;
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      chk("rst_burst_gnt", gnt, 4'b0100);
      n = 0;
      while (pulse_cnt < 2 && n < 20) begin step(); n++; end
      @(posedge clk);
      #1;
      chk("rst_burst_enb_pre", enb, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_burst_gnt_kill", gnt, 0);
      chk("rst_burst_enb_kill", enb, 0);
      chk("rst_burst_done", done, 0);
      chk("rst_burst_busy", busy, 0);
      step();
      chk("rst_burst_done_hold", done, 0);
      chk("rst_burst_enb_hold", enb, 0);
      // First arbitration right after release must start from ptr=0.
      sbq.push_back('{4'b0001, 1});
      req   = 4'b1111;
      len   = 3'd0;
      rst_n = 1'b1;
      step();
      chk("post_rst_first_gnt", gnt, 4'b0001);
      req = '0;
      n = 0;
      while (!done && n < 10) begin step(); n++; end
      chk("post_rst_done", done, 1);
      step();
      step();
      chk("sb_drained_rst", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
